// File: rtl/actuator_pkg.sv
// actuator_pkg: shared definitions for the actuator scan sequencer.
// FSM state encoding, H-bridge pair codes, cell geometry, CCR indices and
// the pure helpers that map a phase onto pad drive values.
package actuator_pkg;

    localparam int NUM_ROWS = 5;
    localparam int NUM_COLS = 2;
    localparam int NUM_DOTS = NUM_ROWS * NUM_COLS;

    // H-bridge pair codes {p,n}; 2'b01 would short the bridge and is never produced
    localparam logic [1:0] HB_HIZ = 2'b10;
    localparam logic [1:0] HB_HI  = 2'b11;
    localparam logic [1:0] HB_LO  = 2'b00;

    localparam int NUM_CCR  = 4;
    localparam int CCR_DEAD = 0;
    localparam int CCR_SET  = 1;
    localparam int CCR_CLR  = 2;
    localparam int CCR_GAP  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEAD1,
        ST_SET,
        ST_DEAD2,
        ST_CLR,
        ST_GAP,
        ST_DONE
    } state_t;

    // Entry point of a column scan: which phase to start in and for which column
    typedef struct packed {
        state_t st;
        logic   col;
    } step_t;

    typedef struct packed {
        logic [2*NUM_ROWS-1:0] hb_rows;
        logic [2*NUM_COLS-1:0] hb_cols;
    } pads_t;

    // Row slice of a dot vector belonging to column c
    function automatic logic [NUM_ROWS-1:0] col_bits(input logic [NUM_DOTS-1:0] v, input logic c);
        return c ? v[NUM_DOTS-1:NUM_ROWS] : v[NUM_ROWS-1:0];
    endfunction

    // H-bridge drive for a phase: SET pulls the column low and lifts rows whose
    // target is 1; CLR lifts the column and pulls rows whose target is 0.
    // Only masked dots are driven; everything else floats.
    function automatic pads_t phase_pads(input state_t st, input logic c,
                                         input logic [NUM_DOTS-1:0] tgt,
                                         input logic [NUM_DOTS-1:0] mask);
        pads_t p;
        logic [NUM_ROWS-1:0] t_c;
        logic [NUM_ROWS-1:0] m_c;
        p.hb_rows = {NUM_ROWS{HB_HIZ}};
        p.hb_cols = {NUM_COLS{HB_HIZ}};
        t_c = col_bits(tgt, c);
        m_c = col_bits(mask, c);
        case (st)
            ST_SET: begin
                p.hb_cols[2*int'(c) +: 2] = HB_LO;
                for (int r = 0; r < NUM_ROWS; r++) begin
                    if (t_c[r] && m_c[r]) p.hb_rows[2*r +: 2] = HB_HI;
                end
            end
            ST_CLR: begin
                p.hb_cols[2*int'(c) +: 2] = HB_HI;
                for (int r = 0; r < NUM_ROWS; r++) begin
                    if (!t_c[r] && m_c[r]) p.hb_rows[2*r +: 2] = HB_LO;
                end
            end
            default: ;
        endcase
        return p;
    endfunction

    // Direct row pads: high exactly while the matching bridge pair drives high
    function automatic logic [NUM_ROWS-1:0] hi_rows(input logic [2*NUM_ROWS-1:0] hb);
        logic [NUM_ROWS-1:0] v;
        for (int r = 0; r < NUM_ROWS; r++) v[r] = (hb[2*r +: 2] == HB_HI);
        return v;
    endfunction

    // Direct column pads: same rule for the column pairs
    function automatic logic [NUM_COLS-1:0] hi_cols(input logic [2*NUM_COLS-1:0] hb);
        logic [NUM_COLS-1:0] v;
        for (int c = 0; c < NUM_COLS; c++) v[c] = (hb[2*c +: 2] == HB_HI);
        return v;
    endfunction

endpackage

// File: rtl/actuator_scan_sequencer_if.sv
// actuator_scan_sequencer_if: control/config inputs and pad outputs of the
// sequencer. master = register file / pad side, slave = sequencer.
interface actuator_scan_sequencer_if
    import actuator_pkg::*;
#(
    parameter int CNT_W = 32
) ();

    logic                  enable;
    logic                  trigger;
    logic [NUM_DOTS-1:0]   b_state;
    logic                  cfg_past;
    logic                  cfg_inv;
    logic [CNT_W-1:0]      ccr0;
    logic [CNT_W-1:0]      ccr1;
    logic [CNT_W-1:0]      ccr2;
    logic [CNT_W-1:0]      ccr3;
    logic [2*NUM_ROWS-1:0] hb_rows;
    logic [2*NUM_COLS-1:0] hb_cols;
    logic [NUM_ROWS-1:0]   rows;
    logic [NUM_COLS-1:0]   cols;
    logic [NUM_DOTS-1:0]   last_state;
    logic                  busy;
    logic                  trigger_out_n;

    modport master (
        output enable, trigger, b_state, cfg_past, cfg_inv, ccr0, ccr1, ccr2, ccr3,
        input  hb_rows, hb_cols, rows, cols, last_state, busy, trigger_out_n
    );

    modport slave (
        input  enable, trigger, b_state, cfg_past, cfg_inv, ccr0, ccr1, ccr2, ccr3,
        output hb_rows, hb_cols, rows, cols, last_state, busy, trigger_out_n
    );

endinterface

// File: rtl/actuator_phase_timer.sv
// actuator_phase_timer: down-counter timing one FSM phase.
// load_i is high during the first cycle of a phase with the phase length on
// val_i; expire_o marks the last cycle of the phase. A length of 0 behaves as 1.
// The first cycle is spent in the load itself, so the register starts at len-2.
module actuator_phase_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] val_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload on phase entry, otherwise count down and stop at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = (val_i > CNT_W'(1)) ? (val_i - CNT_W'(2)) : '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign expire_o = load_i ? (val_i <= CNT_W'(1)) : (cnt_q == '0);

endmodule

// File: rtl/actuator_scan_sequencer.sv
// actuator_scan_sequencer: turns a 10-dot target into timed H-bridge phases
// for a 2x5 bistable actuator cell (DEAD1/SET/DEAD2/CLR/GAP per column),
// then pulses trigger_out_n low for TRIG_OUT_LEN cycles.
// Optional build macro ACTUATOR_SEQ_SKIP_EMPTY_EN: skip SET/CLR phases (and
// their dead time) with nothing to drive, and whole empty columns.
module actuator_scan_sequencer
    import actuator_pkg::*;
#(
    parameter int TRIG_OUT_LEN = 8,
    parameter int CNT_W        = 32
) (
    input  logic                      clock,
    input  logic                      reset_n,
    actuator_scan_sequencer_if.slave  bus
);

    state_t              state_q, state_d;
    logic                col_q, col_d;
    logic [NUM_DOTS-1:0] tgt_q, tgt_d;
    logic [NUM_DOTS-1:0] mask_q, mask_d;
    logic [NUM_DOTS-1:0] last_q, last_d;
    logic                tmr_load_q, tmr_load_d;
    logic [CNT_W-1:0]    tmr_val_q, tmr_val_d;
    logic                tmr_expire;

    pads_t               pads_q, pads_d;
    logic [NUM_ROWS-1:0] rows_q, rows_d;
    logic [NUM_COLS-1:0] cols_q, cols_d;
    logic                busy_q, busy_d;
    logic                trig_n_q, trig_n_d;

    logic [NUM_DOTS-1:0] tgt_new;
    logic [NUM_DOTS-1:0] mask_new;
    logic [CNT_W-1:0]    ccr [NUM_CCR];

    assign ccr[CCR_DEAD] = bus.ccr0;
    assign ccr[CCR_SET]  = bus.ccr1;
    assign ccr[CCR_CLR]  = bus.ccr2;
    assign ccr[CCR_GAP]  = bus.ccr3;

    // Target and drive mask as they would be latched by a trigger this cycle
    assign tgt_new  = bus.cfg_inv ? ~bus.b_state : bus.b_state;
    assign mask_new = bus.cfg_past ? (tgt_new ^ last_q) : {NUM_DOTS{1'b1}};

    actuator_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i    (clock),
        .rst_ni   (reset_n),
        .load_i   (tmr_load_q),
        .val_i    (tmr_val_q),
        .expire_o (tmr_expire)
    );

`ifdef ACTUATOR_SEQ_SKIP_EMPTY_EN
    step_t entry_c0;
    step_t entry_c1;
    logic  clr_pending;

    // First phase with something to drive, starting at column c; DONE if none
    function automatic step_t enter_col(input logic [NUM_DOTS-1:0] set_v,
                                        input logic [NUM_DOTS-1:0] clr_v,
                                        input logic c);
        step_t s;
        s.col = c;
        s.st  = ST_DONE;
        if (|col_bits(set_v, c)) begin
            s.st = ST_DEAD1;
        end else if (|col_bits(clr_v, c)) begin
            s.st = ST_DEAD2;
        end else if (!c) begin
            if (|col_bits(set_v, 1'b1)) begin
                s.col = 1'b1;
                s.st  = ST_DEAD1;
            end else if (|col_bits(clr_v, 1'b1)) begin
                s.col = 1'b1;
                s.st  = ST_DEAD2;
            end
        end
        return s;
    endfunction

    assign entry_c0    = enter_col(tgt_new & mask_new, ~tgt_new & mask_new, 1'b0);
    assign entry_c1    = enter_col(tgt_q & mask_q, ~tgt_q & mask_q, 1'b1);
    assign clr_pending = |col_bits(~tgt_q & mask_q, col_q);
`endif

    // Next-state, phase length selection and pad values for the coming cycle
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        tgt_d   = tgt_q;
        mask_d  = mask_q;
        last_d  = last_q;

        if (state_q != ST_IDLE && !bus.enable) begin
            // Enable loss aborts immediately; the partial pattern is not recorded
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.trigger && bus.enable) begin
                        tgt_d  = tgt_new;
                        mask_d = mask_new;
`ifdef ACTUATOR_SEQ_SKIP_EMPTY_EN
                        state_d = entry_c0.st;
                        col_d   = entry_c0.col;
`else
                        state_d = ST_DEAD1;
                        col_d   = 1'b0;
`endif
                    end
                end
                ST_DEAD1: if (tmr_expire) state_d = ST_SET;
                ST_SET: begin
                    if (tmr_expire) begin
`ifdef ACTUATOR_SEQ_SKIP_EMPTY_EN
                        state_d = clr_pending ? ST_DEAD2 : ST_GAP;
`else
                        state_d = ST_DEAD2;
`endif
                    end
                end
                ST_DEAD2: if (tmr_expire) state_d = ST_CLR;
                ST_CLR:   if (tmr_expire) state_d = ST_GAP;
                ST_GAP: begin
                    if (tmr_expire) begin
                        if (!col_q) begin
`ifdef ACTUATOR_SEQ_SKIP_EMPTY_EN
                            state_d = entry_c1.st;
                            col_d   = entry_c1.col;
`else
                            state_d = ST_DEAD1;
                            col_d   = 1'b1;
`endif
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE:  if (tmr_expire) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end

        // The pattern counts as applied once the last phase has finished
        if (state_d == ST_DONE && state_q != ST_DONE) last_d = tgt_d;

        tmr_load_d = (state_d != state_q);
        case (state_d)
            ST_DEAD1, ST_DEAD2: tmr_val_d = ccr[CCR_DEAD];
            ST_SET:             tmr_val_d = ccr[CCR_SET];
            ST_CLR:             tmr_val_d = ccr[CCR_CLR];
            ST_GAP:             tmr_val_d = ccr[CCR_GAP];
            ST_DONE:            tmr_val_d = CNT_W'(TRIG_OUT_LEN);
            default:            tmr_val_d = '0;
        endcase

        pads_d   = phase_pads(state_d, col_d, tgt_d, mask_d);
        rows_d   = hi_rows(pads_d.hb_rows);
        cols_d   = hi_cols(pads_d.hb_cols);
        busy_d   = (state_d != ST_IDLE);
        trig_n_d = (state_d != ST_DONE);
    end

    // Sequencer state, phase timer request and registered pad outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            col_q      <= 1'b0;
            tgt_q      <= '0;
            mask_q     <= '0;
            last_q     <= '0;
            tmr_load_q <= 1'b0;
            tmr_val_q  <= '0;
            pads_q     <= '{hb_rows: {NUM_ROWS{HB_HIZ}}, hb_cols: {NUM_COLS{HB_HIZ}}};
            rows_q     <= '0;
            cols_q     <= '0;
            busy_q     <= 1'b0;
            trig_n_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            tgt_q      <= tgt_d;
            mask_q     <= mask_d;
            last_q     <= last_d;
            tmr_load_q <= tmr_load_d;
            tmr_val_q  <= tmr_val_d;
            pads_q     <= pads_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            busy_q     <= busy_d;
            trig_n_q   <= trig_n_d;
        end
    end

    assign bus.hb_rows       = pads_q.hb_rows;
    assign bus.hb_cols       = pads_q.hb_cols;
    assign bus.rows          = rows_q;
    assign bus.cols          = cols_q;
    assign bus.last_state    = last_q;
    assign bus.busy          = busy_q;
    assign bus.trigger_out_n = trig_n_q;

endmodule

// File: tb/tb_actuator_scan_sequencer.sv
// tb_actuator_scan_sequencer: directed bench for actuator_scan_sequencer with
// a bistable cell model driven from the H-bridge pads.
module tb_actuator_scan_sequencer;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    actuator_scan_sequencer_if #(.CNT_W(32)) bus_if ();

    actuator_scan_sequencer #(
        .TRIG_OUT_LEN (8),
        .CNT_W        (32)
    ) dut (
        .clock   (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    int nvec = 0;
    int nmis = 0;

    logic [9:0] dots;
    int         set_cnt [10];
    int         clr_cnt [10];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cell model and pad sanity, sampled on the falling edge
    always @(negedge clk) begin : cell_model
        logic [1:0] rp;
        logic [1:0] cp;
        logic       bad01;
        int         ncols;
        if (!reset_n) begin
            dots = '0;
        end else begin
            bad01 = 1'b0;
            ncols = 0;
            for (int r = 0; r < 5; r++) if (bus_if.hb_rows[2*r +: 2] == 2'b01) bad01 = 1'b1;
            for (int c = 0; c < 2; c++) begin
                cp = bus_if.hb_cols[2*c +: 2];
                if (cp == 2'b01) bad01 = 1'b1;
                if (cp != 2'b10) ncols++;
            end
            nvec++;
            assert (bad01 === 1'b0) else begin
                nmis++;
                $error("FAIL shoot_through: rows %b cols %b", bus_if.hb_rows, bus_if.hb_cols);
            end
            nvec++;
            assert ((ncols <= 1) === 1'b1) else begin
                nmis++;
                $error("FAIL two_cols: observed %0d driven columns, at most 1 required", ncols);
            end
            for (int c = 0; c < 2; c++) begin
                cp = bus_if.hb_cols[2*c +: 2];
                for (int r = 0; r < 5; r++) begin
                    rp = bus_if.hb_rows[2*r +: 2];
                    if (rp == 2'b11 && cp == 2'b00) begin
                        dots[c*5+r] = 1'b1;
                        set_cnt[c*5+r]++;
                    end
                    if (rp == 2'b00 && cp == 2'b11) begin
                        dots[c*5+r] = 1'b0;
                        clr_cnt[c*5+r]++;
                    end
                end
            end
        end
    end

    task automatic clear_counts();
        for (int i = 0; i < 10; i++) begin
            set_cnt[i] = 0;
            clr_cnt[i] = 0;
        end
    endtask

    function automatic int sum_set();
        int s = 0;
        for (int i = 0; i < 10; i++) s += set_cnt[i];
        return s;
    endfunction

    function automatic int sum_clr();
        int s = 0;
        for (int i = 0; i < 10; i++) s += clr_cnt[i];
        return s;
    endfunction

    // Called at a falling edge: pulse trigger for one rising edge, then measure
    // samples until trigger_out_n falls (lat) and how long it stays low.
    task automatic run_trigger(output int lat, output int lowlen, output logic busy1,
                               output logic [3:0] cols1, output logic [3:0] cols2);
        bus_if.trigger = 1'b1;
        @(negedge clk);
        bus_if.trigger = 1'b0;
        lat   = 1;
        busy1 = bus_if.busy;
        cols1 = bus_if.hb_cols;
        cols2 = 4'h0;
        while (bus_if.trigger_out_n !== 1'b0 && lat < 5000) begin
            @(negedge clk);
            lat++;
            if (lat == 2) cols2 = bus_if.hb_cols;
        end
        lowlen = 0;
        while (bus_if.trigger_out_n === 1'b0 && lowlen < 100) begin
            @(negedge clk);
            lowlen++;
        end
    endtask

    initial begin
        int         lat;
        int         lowlen;
        int         lows;
        logic       busy1;
        logic [3:0] c1;
        logic [3:0] c2;
        logic [9:0] rb;
        logic [9:0] expt;

        reset_n = 1'b0;
        bus_if.enable   = 1'b0;
        bus_if.trigger  = 1'b0;
        bus_if.b_state  = 10'h000;
        bus_if.cfg_past = 1'b0;
        bus_if.cfg_inv  = 1'b0;
        bus_if.ccr0 = 32'd4;
        bus_if.ccr1 = 32'd15;
        bus_if.ccr2 = 32'd128;
        bus_if.ccr3 = 32'd240;
        repeat (3) @(negedge clk);

        chk("rst_hb_rows", 32'(bus_if.hb_rows), 32'h2AA);
        chk("rst_hb_cols", 32'(bus_if.hb_cols), 32'hA);
        chk("rst_rows", 32'(bus_if.rows), 32'h0);
        chk("rst_cols", 32'(bus_if.cols), 32'h0);
        chk("rst_last", 32'(bus_if.last_state), 32'h0);
        chk("rst_busy", 32'(bus_if.busy), 32'h0);
        chk("rst_trig_n", 32'(bus_if.trigger_out_n), 32'h1);

        reset_n = 1'b1;
        bus_if.enable = 1'b1;
        repeat (2) @(negedge clk);

        // Single dot: row0/col0 set for 15 cycles, all other dots cleared
        clear_counts();
        bus_if.b_state = 10'h001;
        run_trigger(lat, lowlen, busy1, c1, c2);
        chk("t1_busy_next", 32'(busy1), 32'h1);
        chk("t1_latency", 32'(lat), 32'd783);
        chk("t1_low_len", 32'(lowlen), 32'd8);
        chk("t1_busy_after", 32'(bus_if.busy), 32'h0);
        chk("t1_set0", 32'(set_cnt[0]), 32'd15);
        chk("t1_set_total", 32'(sum_set()), 32'd15);
        chk("t1_clr0", 32'(clr_cnt[0]), 32'd0);
        chk("t1_clr1", 32'(clr_cnt[1]), 32'd128);
        chk("t1_clr5", 32'(clr_cnt[5]), 32'd128);
        chk("t1_last", 32'(bus_if.last_state), 32'h001);
        chk("t1_dots", 32'(dots), 32'h001);

        // All ones, then the same pattern through inversion
        clear_counts();
        bus_if.b_state = 10'h3FF;
        run_trigger(lat, lowlen, busy1, c1, c2);
        chk("t2_set9", 32'(set_cnt[9]), 32'd15);
        chk("t2_clr_total", 32'(sum_clr()), 32'd0);
        chk("t2_last", 32'(bus_if.last_state), 32'h3FF);
        chk("t2_dots", 32'(dots), 32'h3FF);

        clear_counts();
        bus_if.cfg_inv = 1'b1;
        bus_if.b_state = 10'h000;
        run_trigger(lat, lowlen, busy1, c1, c2);
        chk("t2i_set4", 32'(set_cnt[4]), 32'd15);
        chk("t2i_clr_total", 32'(sum_clr()), 32'd0);
        chk("t2i_last", 32'(bus_if.last_state), 32'h3FF);
        chk("t2i_dots", 32'(dots), 32'h3FF);

        // Past mode: only the changed dot is driven, in CLR only
        clear_counts();
        bus_if.cfg_inv  = 1'b0;
        bus_if.cfg_past = 1'b1;
        bus_if.b_state  = 10'h3FE;
        run_trigger(lat, lowlen, busy1, c1, c2);
        chk("t3_latency", 32'(lat), 32'd783);
        chk("t3_set_total", 32'(sum_set()), 32'd0);
        chk("t3_clr0", 32'(clr_cnt[0]), 32'd128);
        chk("t3_clr_total", 32'(sum_clr()), 32'd128);
        chk("t3_last", 32'(bus_if.last_state), 32'h3FE);
        chk("t3_dots", 32'(dots), 32'h3FE);

        // ccr0 = 0: dead time is one cycle
        bus_if.cfg_past = 1'b0;
        bus_if.ccr0 = 32'd0;
        bus_if.ccr1 = 32'd2;
        bus_if.ccr2 = 32'd3;
        bus_if.ccr3 = 32'd1;
        bus_if.b_state = 10'h021;
        run_trigger(lat, lowlen, busy1, c1, c2);
        chk("t4_dead_cols", 32'(c1), 32'hA);
        chk("t4_set_cols", 32'(c2), 32'h8);
        chk("t4_latency", 32'(lat), 32'd17);
        chk("t4_last", 32'(bus_if.last_state), 32'h021);
        chk("t4_dots", 32'(dots), 32'h021);

        // Random targets with random past/inversion settings
        for (int i = 0; i < 200; i++) begin
            rb = 10'($urandom);
            bus_if.b_state  = rb;
            bus_if.cfg_past = 1'($urandom);
            bus_if.cfg_inv  = 1'($urandom);
            expt = bus_if.cfg_inv ? ~rb : rb;
            run_trigger(lat, lowlen, busy1, c1, c2);
            chk("rnd_latency", 32'(lat), 32'd17);
            chk("rnd_last", 32'(bus_if.last_state), 32'(expt));
            chk("rnd_dots", 32'(dots), 32'(expt));
        end

        // Second trigger while busy is ignored
        bus_if.cfg_past = 1'b0;
        bus_if.cfg_inv  = 1'b0;
        bus_if.b_state  = 10'h155;
        bus_if.trigger  = 1'b1;
        @(negedge clk);
        bus_if.trigger = 1'b0;
        repeat (2) @(negedge clk);
        bus_if.b_state = 10'h2AA;
        bus_if.trigger = 1'b1;
        @(negedge clk);
        bus_if.trigger = 1'b0;
        lat = 0;
        while (bus_if.trigger_out_n !== 1'b0 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("t5_done_seen", 32'(bus_if.trigger_out_n), 32'h0);
        lat = 0;
        while (bus_if.trigger_out_n === 1'b0 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus_if.trigger_out_n === 1'b0) lows++;
        end
        chk("t5_no_second_run", 32'(lows), 32'd0);
        chk("t5_busy", 32'(bus_if.busy), 32'h0);
        chk("t5_last", 32'(bus_if.last_state), 32'h155);
        chk("t5_dots", 32'(dots), 32'h155);

        // Trigger coinciding with enable low is dropped
        bus_if.enable  = 1'b0;
        bus_if.trigger = 1'b1;
        @(negedge clk);
        bus_if.trigger = 1'b0;
        chk("t6_busy", 32'(bus_if.busy), 32'h0);
        chk("t6_hb_cols", 32'(bus_if.hb_cols), 32'hA);
        bus_if.enable = 1'b1;
        @(negedge clk);

        // Enable dropped during SET aborts without recording the pattern
        bus_if.ccr0 = 32'd4;
        bus_if.ccr1 = 32'd15;
        bus_if.ccr2 = 32'd128;
        bus_if.ccr3 = 32'd240;
        bus_if.b_state = 10'h3FF;
        bus_if.trigger = 1'b1;
        @(negedge clk);
        bus_if.trigger = 1'b0;
        repeat (6) @(negedge clk);
        chk("t7_in_set_cols", 32'(bus_if.hb_cols), 32'h8);
        chk("t7_in_set_rows", 32'(bus_if.hb_rows), 32'h3FF);
        bus_if.enable = 1'b0;
        @(negedge clk);
        chk("t7_abort_rows", 32'(bus_if.hb_rows), 32'h2AA);
        chk("t7_abort_cols", 32'(bus_if.hb_cols), 32'hA);
        chk("t7_abort_busy", 32'(bus_if.busy), 32'h0);
        chk("t7_abort_trig_n", 32'(bus_if.trigger_out_n), 32'h1);
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_if.trigger_out_n === 1'b0) lows++;
        end
        chk("t7_no_pulse", 32'(lows), 32'd0);
        chk("t7_last_kept", 32'(bus_if.last_state), 32'h155);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
